conv_layer_sequencer: RTL and testbench

Controller that runs the `conv2d` engine through a configurable chain of up to NUM_LAYERS convolution passes back to back. It owns the engine's start/done handshake and ping-pong buffer selection. It arbitrates buffer ownership between the engine and a host loader, and a per-layer watchdog aborts a hung engine. It sits between the host/CPU control interface and one `conv2d` instance plus its two activation buffers.

---
 rtl/conv_layer_sequencer_pkg.sv | 31 +++
 rtl/conv_layer_sequencer_if.sv | 37 +++
 rtl/conv_layer_sequencer_watchdog.sv | 45 ++++
 rtl/conv_layer_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer: state encoding,
// watchdog defaults, cycle-counter width and small state-class helpers.
package conv_ctrl_pkg;

  localparam int STATE_W            = 3;
  localparam int TIMEOUT_CYCLES_DEF = 4095;
  localparam int WDOG_W_DEF         = 12;
  localparam int TOTAL_W            = 32;

  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_FINISH    = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_e;

  // States in which a chain is in flight and the busy-cycle counter runs.
  function automatic logic is_busy_state(input seq_state_e s);
    return (s == ST_LAUNCH) || (s == ST_WAIT_DONE) || (s == ST_RELEASE);
  endfunction

  // States from which a new run may be accepted or the host may take the buffers.
  function automatic logic is_parked_state(input seq_state_e s);
    return (s == ST_IDLE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/handshake bundle between the sequencer, the host control port and
// the conv2d engine. The master side is the sequencer itself.
interface conv_layer_sequencer_if
  import conv_ctrl_pkg::*;
#(
  parameter int LAYER_W = 2
) ();

  // host control side
  logic               run;
  logic [LAYER_W-1:0] cfg_last_layer;
  logic               host_req;
  logic               host_grant;
  logic               busy;
  logic               done;
  logic               error;
  logic [TOTAL_W-1:0] total_cycles;

  // engine side
  logic               eng_start;
  logic               eng_done;
  logic [LAYER_W-1:0] layer_idx;
  logic               src_buf_sel;

  modport master (
    input  run, cfg_last_layer, host_req, eng_done,
    output host_grant, busy, done, error, total_cycles,
           eng_start, layer_idx, src_buf_sel
  );

  modport slave (
    output run, cfg_last_layer, host_req, eng_done,
    input  host_grant, busy, done, error, total_cycles,
           eng_start, layer_idx, src_buf_sel
  );

endinterface

// File: rtl/conv_layer_sequencer_watchdog.sv
// Per-layer watchdog: clearable, enabled up-counter that stops at the
// terminal count and flags expiry while enabled.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int WDOG_W         = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [WDOG_W-1:0] count_o,
  output logic              expired_o
);

  localparam logic [WDOG_W-1:0] TERM = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] count_q;
  logic [WDOG_W-1:0] count_d;
  logic              at_term;

  assign at_term = (count_q == TERM);

  // Clear wins over enable; the count parks at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !at_term) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = en_i && at_term;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs the conv2d engine through a chain of layers, owns the start/done
// handshake and ping-pong source select, arbitrates buffer ownership with
// the host loader and aborts a hung engine through a per-layer watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | parked, accepts a run or hands the buffers to the host
// LAUNCH    | waiting for engine done to be low, then raises eng_start
// WAIT_DONE | eng_start high, waiting for engine done
// RELEASE   | eng_start dropped, waiting for engine done to fall
// FINISH    | one-cycle chain-complete pulse
// ERROR     | watchdog fired; parked like IDLE with error held high
module conv_layer_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int LAYER_W        = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int WDOG_W         = WDOG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_sequencer_if.master bus
);

  localparam int LAST_MAX_I = NUM_LAYERS - 1;

  seq_state_e         state_q, state_d;
  logic [LAYER_W-1:0] last_q, last_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               eng_start_q, eng_start_d;
  logic               host_grant_q, host_grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic               run_accept;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_expired;
  logic [WDOG_W-1:0]  wd_count;
  logic               wd_count_unused;

  // Final-layer index is clamped to the last layer this instance supports.
  function automatic logic [LAYER_W-1:0] clamp_last(input logic [LAYER_W-1:0] cfg);
    logic [31:0] cfg_w;
    cfg_w = 32'(cfg);
    if (cfg_w > 32'(LAST_MAX_I)) begin
      return LAYER_W'(LAST_MAX_I);
    end
    return cfg;
  endfunction

  // The host holding the buffers blocks a run; a run beats a same-cycle host request.
  assign run_accept = is_parked_state(state_q) && bus.run && !host_grant_q;

  assign wd_clr = (state_q == ST_LAUNCH);
  assign wd_en  = (state_q == ST_WAIT_DONE) || (state_q == ST_RELEASE);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WDOG_W         (WDOG_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .count_o   (wd_count),
    .expired_o (wd_expired)
  );

  // The raw count is a debug tap; control only needs the expiry flag.
  assign wd_count_unused = ^wd_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; engine progress takes priority over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (run_accept) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (!bus.eng_done) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.eng_done)     state_d = ST_RELEASE;
        else if (wd_expired)  state_d = ST_ERROR;
      end
      ST_RELEASE: begin
        if (!bus.eng_done) begin
          state_d = (layer_q == last_q) ? ST_FINISH : ST_LAUNCH;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of every registered output and the latched chain length.
  always_comb begin
    last_d       = last_q;
    layer_d      = layer_q;
    eng_start_d  = eng_start_q;
    error_d      = error_q;
    total_d      = total_q;
    host_grant_d = 1'b0;

    if (run_accept) begin
      last_d  = clamp_last(bus.cfg_last_layer);
      layer_d = '0;
      error_d = 1'b0;
      total_d = '0;
    end else if (is_busy_state(state_q) && (total_q != TOTAL_MAX)) begin
      total_d = total_q + 1'b1;
    end

    if ((state_q == ST_LAUNCH) && !bus.eng_done) begin
      eng_start_d = 1'b1;
    end
    if ((state_q == ST_WAIT_DONE) && bus.eng_done) begin
      eng_start_d = 1'b0;
    end

    if ((state_q == ST_RELEASE) && !bus.eng_done && (layer_q != last_q)) begin
      layer_d = layer_q + 1'b1;
    end

    if (state_d == ST_ERROR) begin
      eng_start_d = 1'b0;
      error_d     = 1'b1;
    end

    if (is_parked_state(state_q)) begin
      host_grant_d = bus.host_req && !run_accept;
    end

    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_FINISH);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= '0;
      layer_q      <= '0;
      eng_start_q  <= 1'b0;
      host_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      total_q      <= '0;
    end else begin
      last_q       <= last_d;
      layer_q      <= layer_d;
      eng_start_q  <= eng_start_d;
      host_grant_q <= host_grant_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      total_q      <= total_d;
    end
  end

  assign bus.eng_start    = eng_start_q;
  assign bus.layer_idx    = layer_q;
  assign bus.src_buf_sel  = layer_q[0];
  assign bus.host_grant   = host_grant_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.total_cycles = total_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed + randomized bench for conv_layer_sequencer with a registered
// conv2d engine model and a chain-level reference model.
module tb_conv_layer_sequencer;

  localparam int NL = 3;
  localparam int LW = 2;
  localparam int TO = 40;
  localparam int WW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_sequencer_if #(.LAYER_W(LW)) ifc ();

  conv_layer_sequencer #(
    .NUM_LAYERS     (NL),
    .LAYER_W        (LW),
    .TIMEOUT_CYCLES (TO),
    .WDOG_W         (WW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  // engine model: done rises lat_arr[layer] cycles after start is first seen
  int   lat_arr[4];
  bit   eng_mute = 1'b0;
  logic stale_done = 1'b0;
  logic eng_done_r;
  int   eng_cnt;

  assign ifc.eng_done = eng_done_r | stale_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done_r <= 1'b0;
      eng_cnt    <= 0;
    end else if (!ifc.eng_start) begin
      eng_done_r <= 1'b0;
      eng_cnt    <= 0;
    end else if (!eng_done_r && !eng_mute) begin
      if (eng_cnt + 1 >= lat_arr[ifc.layer_idx]) eng_done_r <= 1'b1;
      eng_cnt <= eng_cnt + 1;
    end
  end

  // monitor, sampled just after each rising edge
  int   n_rises, n_done, n_viol, n_grant_hi;
  int   seq_layer[$];
  int   seq_src[$];
  logic prev_start = 1'b0;

  always @(posedge clk) begin
    #2;
    if (ifc.eng_start && !prev_start) begin
      n_rises++;
      seq_layer.push_back(int'(ifc.layer_idx));
      seq_src.push_back(int'(ifc.src_buf_sel));
      if (ifc.eng_done) n_viol++;
    end
    prev_start = ifc.eng_start;
    if (ifc.done) n_done++;
    if (ifc.host_grant) n_grant_hi++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic clear_mon();
    n_rises = 0; n_done = 0; n_viol = 0; n_grant_hi = 0;
    seq_layer.delete();
    seq_src.delete();
  endtask

  function automatic int n_layers(input int cfg);
    return (cfg >= NL) ? NL : cfg + 1;
  endfunction

  // every layer costs its engine latency plus four cycles of handshake
  function automatic int exp_total(input int n);
    int t;
    t = 0;
    for (int i = 0; i < n; i++) t += lat_arr[i] + 4;
    return t;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_eng_start"},    ifc.eng_start,    0);
    check({pfx, "_layer_idx"},    ifc.layer_idx,    0);
    check({pfx, "_src_buf_sel"},  ifc.src_buf_sel,  0);
    check({pfx, "_host_grant"},   ifc.host_grant,   0);
    check({pfx, "_busy"},         ifc.busy,         0);
    check({pfx, "_done"},         ifc.done,         0);
    check({pfx, "_error"},        ifc.error,        0);
    check({pfx, "_total_cycles"}, ifc.total_cycles, 0);
  endtask

  // leaves the caller at the first sample after the run was taken
  task automatic launch_run(input logic [LW-1:0] cfg);
    @(negedge clk);
    ifc.run = 1'b1;
    ifc.cfg_last_layer = cfg;
    @(negedge clk);
    ifc.run = 1'b0;
    ifc.cfg_last_layer = LW'($urandom);
  endtask

  task automatic wait_done(input int k0, input int limit, output int ncyc, output bit seen);
    ncyc = k0;
    seen = ifc.done;
    while (!seen && ncyc < limit) begin
      @(negedge clk);
      ncyc++;
      seen = ifc.done;
    end
  endtask

  task automatic finish_checks(input int n, input int et, input int ncyc, input bit seen);
    bit ok_seq;
    check("done_seen", seen, 1);
    check("done_latency", ncyc, et + 1);
    check("total_cycles", ifc.total_cycles, et);
    check("final_layer", ifc.layer_idx, n - 1);
    check("busy_at_done", ifc.busy, 0);
    @(negedge clk);
    check("done_one_cycle", ifc.done, 0);
    check("done_pulses", n_done, 1);
    check("start_rises", n_rises, n);
    check("start_while_done", n_viol, 0);
    ok_seq = (seq_layer.size() == n) && (seq_src.size() == n);
    if (ok_seq) begin
      for (int i = 0; i < n; i++) begin
        if (seq_layer[i] != i || seq_src[i] != (i % 2)) ok_seq = 1'b0;
      end
    end
    check("layer_src_sequence", ok_seq, 1);
  endtask

  task automatic run_and_check(input logic [LW-1:0] cfg);
    int  n, et, ncyc;
    bit  seen;
    n  = n_layers(int'(cfg));
    et = exp_total(n);
    clear_mon();
    launch_run(cfg);
    check("error_cleared", ifc.error, 0);
    check("busy_after_run", ifc.busy, 1);
    wait_done(1, 4000, ncyc, seen);
    finish_checks(n, et, ncyc, seen);
  endtask

  initial begin
    int  ncyc, cnt, et;
    bit  seen, flag;

    ifc.run = 1'b0;
    ifc.cfg_last_layer = '0;
    ifc.host_req = 1'b0;
    for (int i = 0; i < 4; i++) lat_arr[i] = 20;

    // power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // single layer, 20-cycle engine
    clear_mon();
    launch_run(2'd0);
    check("single_start_s1", ifc.eng_start, 0);
    check("single_busy_s1", ifc.busy, 1);
    @(negedge clk);
    check("single_start_s2", ifc.eng_start, 1);
    wait_done(2, 4000, ncyc, seen);
    finish_checks(1, 24, ncyc, seen);
    check("single_busy_after", ifc.busy, 0);

    // three-layer chain, random latencies
    for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(3, 30);
    run_and_check(2'd2);

    // clamp: last layer 3 on a three-layer instance
    for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(1, 30);
    run_and_check(2'd3);

    // randomized chains
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(1, 30);
      run_and_check(LW'($urandom_range(0, 3)));
    end

    // watchdog: engine never answers
    eng_mute = 1'b1;
    clear_mon();
    launch_run(LW'($urandom_range(0, 3)));
    cnt = 0;
    while (!ifc.eng_start && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("wdog_start_seen", ifc.eng_start, 1);
    cnt = 0;
    while (!ifc.error && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("wdog_latency", cnt, TO + 1);
    check("wdog_error", ifc.error, 1);
    check("wdog_eng_start", ifc.eng_start, 0);
    check("wdog_busy", ifc.busy, 0);
    check("wdog_total", ifc.total_cycles, TO + 2);
    check("wdog_layer", ifc.layer_idx, 0);
    repeat (5) @(negedge clk);
    check("wdog_error_sticky", ifc.error, 1);
    check("wdog_no_done", n_done, 0);
    eng_mute = 1'b0;
    for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(1, 30);
    run_and_check(2'd1);

    // arbitration: run and host_req together, run wins
    for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(1, 30);
    clear_mon();
    @(negedge clk);
    ifc.run = 1'b1;
    ifc.host_req = 1'b1;
    ifc.cfg_last_layer = 2'd1;
    @(negedge clk);
    ifc.run = 1'b0;
    check("arb_busy", ifc.busy, 1);
    wait_done(1, 4000, ncyc, seen);
    check("arb_done_seen", seen, 1);
    check("arb_total", ifc.total_cycles, exp_total(2));
    check("arb_grant_held_off", n_grant_hi, 0);
    @(negedge clk);
    check("arb_grant_idle0", ifc.host_grant, 0);
    @(negedge clk);
    check("arb_grant_rise", ifc.host_grant, 1);
    // run while host owns the buffers is dropped
    clear_mon();
    ifc.run = 1'b1;
    @(negedge clk);
    ifc.run = 1'b0;
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.busy) flag = 1'b1;
    end
    check("arb_run_ignored_busy", flag, 0);
    check("arb_run_ignored_start", n_rises, 0);
    check("arb_grant_kept", ifc.host_grant, 1);
    ifc.host_req = 1'b0;
    @(negedge clk);
    check("arb_grant_drop", ifc.host_grant, 0);

    // stale done held high at run
    lat_arr[0] = $urandom_range(1, 30);
    stale_done = 1'b1;
    clear_mon();
    launch_run(2'd0);
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ifc.eng_start) flag = 1'b1;
    end
    check("stale_start_held", flag, 0);
    check("stale_busy", ifc.busy, 1);
    stale_done = 1'b0;
    @(negedge clk);
    check("stale_start_after", ifc.eng_start, 1);
    et = lat_arr[0] + 4 + 6;
    wait_done(8, 4000, ncyc, seen);
    finish_checks(1, et, ncyc, seen);

    // asynchronous reset in the middle of WAIT_DONE
    lat_arr[0] = 30;
    clear_mon();
    launch_run(2'd1);
    repeat (5) @(negedge clk);
    check("rst_pre_start", ifc.eng_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_done", n_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) lat_arr[i] = $urandom_range(1, 30);
    run_and_check(2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
